speed_ticker: RTL and testbench

Consumer end of the speed-control interface: takes the one-cycle `enable` / `up_down` commands produced by the key-decoding state machine and turns them into a saturating speed level. From that level it generates a periodic one-cycle tick strobe that drives the downstream display/animation logic. It sits between the key FSM and any block that advances at a user-selected rate; `oLEVEL` also feeds the 7-segment display.

---
 rtl/speed_ticker.sv | 74 +++++++
 tb/tb_speed_ticker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/speed_ticker.sv
// speed_ticker: turns key-FSM up/down strobes into a saturating speed level and a periodic one-cycle tick
module speed_ticker #(
    parameter int LEVELS = 8,
    parameter int BASE_DIV = 6_250_000,
    parameter int RESET_LEVEL = 1,
    localparam int LW = $clog2(LEVELS)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iENABLE,
    input  logic          iUP_DOWN,
    output logic [LW-1:0] oLEVEL,
    output logic          oTICK,
    output logic          oSAT,
    output logic          oMAX,
    output logic          oMIN
);
    localparam int CW_RAW = $clog2(BASE_DIV * (LEVELS - 1));
    localparam int CW = CW_RAW < 1 ? 1 : CW_RAW;
    localparam logic [LW-1:0] MAX_L = LW'(LEVELS - 1);
    localparam logic [LW-1:0] RST_L = LW'(RESET_LEVEL);

    logic          en_s1_q, en_s2_q, en_prev_q, ud_s1_q, ud_s2_q;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d, sat_q, sat_d;
    logic          cmd, at_lim, accept, wrap;
    logic [31:0]   period, last;

    always_comb begin
        cmd     = en_s2_q & ~en_prev_q;
        at_lim  = ud_s2_q ? level_q == MAX_L : level_q == '0;
        accept  = cmd & ~at_lim;
        sat_d   = cmd & at_lim;
        level_d = accept ? (ud_s2_q ? level_q + LW'(1) : level_q - LW'(1)) : level_q;
        // period is a constant multiply of the remaining level count, widened before compare
        period  = 32'(BASE_DIV) * (32'(LEVELS) - 32'(level_q));
        last    = period - 32'd1;
        wrap    = level_q != '0 && 32'(cnt_q) == last;
        // an accepted command restarts the period and suppresses a coincident tick
        cnt_d   = (accept || level_q == '0 || wrap) ? '0 : cnt_q + CW'(1);
        tick_d  = wrap & ~accept;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_prev_q <= 1'b0;
            ud_s1_q   <= 1'b0;
            ud_s2_q   <= 1'b0;
            level_q   <= RST_L;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            en_s1_q   <= iENABLE;
            en_s2_q   <= en_s1_q;
            en_prev_q <= en_s2_q;
            ud_s1_q   <= iUP_DOWN;
            ud_s2_q   <= ud_s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            sat_q     <= sat_d;
        end
    end

    assign oLEVEL = level_q;
    assign oTICK  = tick_q;
    assign oSAT   = sat_q;
    assign oMAX   = level_q == MAX_L;
    assign oMIN   = level_q == '0;
endmodule

// File: tb/tb_speed_ticker.sv
// tb_speed_ticker: directed table plus hand sequences for speed_ticker with LEVELS=8, BASE_DIV=4, RESET_LEVEL=1
module tb_speed_ticker;
    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iENABLE = 1'b0;
    logic       iUP_DOWN = 1'b0;
    logic [2:0] oLEVEL;
    logic       oTICK, oSAT, oMAX, oMIN;
    int n_checks = 0;
    int n_fail = 0;
    int tick_cnt = 0;
    int sat_cnt = 0;

    typedef struct {
        logic ud;
        int   lvl;
        int   sat;
        logic mx;
        logic mn;
    } vec_t;
    vec_t vecs[14];

    speed_ticker #(.LEVELS(8), .BASE_DIV(4), .RESET_LEVEL(1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iENABLE(iENABLE), .iUP_DOWN(iUP_DOWN),
        .oLEVEL(oLEVEL), .oTICK(oTICK), .oSAT(oSAT), .oMAX(oMAX), .oMIN(oMIN)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
        if (oTICK) tick_cnt++;
        if (oSAT) sat_cnt++;
    endtask

    task automatic pulse(input logic ud);
        iENABLE = 1'b1;
        iUP_DOWN = ud;
        step();
        iENABLE = 1'b0;
        repeat (4) step();
    endtask

    // steps until the next tick; exp < 0 only synchronises to a tick
    task automatic measure(input string name, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!oTICK && n < 400);
        if (!oTICK) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no tick within %0d cycles, expected %0d", name, n, exp);
        end else if (exp >= 0) begin
            check(name, n, exp);
        end
    endtask

    task automatic run_vec(input int i);
        sat_cnt = 0;
        pulse(vecs[i].ud);
        check($sformatf("vec%0d level", i), oLEVEL, vecs[i].lvl);
        check($sformatf("vec%0d sat", i), sat_cnt, vecs[i].sat);
        check($sformatf("vec%0d max", i), oMAX, vecs[i].mx);
        check($sformatf("vec%0d min", i), oMIN, vecs[i].mn);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 6, 0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 7, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 6, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 0, 0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 0, 1, 1'b0, 1'b1};

        repeat (3) @(posedge iCLK);
        #2;
        check("reset level", oLEVEL, 1);
        check("reset tick", oTICK, 0);
        check("reset sat", oSAT, 0);
        check("reset max", oMAX, 0);
        check("reset min", oMIN, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        sat_cnt = 0;
        measure("first tick after release", 28);
        measure("tick period level 1", 28);
        check("no sat at level 1", sat_cnt, 0);

        for (int i = 0; i < 6; i++) run_vec(i);
        measure("sync level 7", -1);
        measure("tick period level 7", 4);
        tick_cnt = 0;
        sat_cnt = 0;
        pulse(1'b1);
        check("sat at top", sat_cnt, 1);
        check("level stays 7", oLEVEL, 7);
        check("ticks during rejected up", tick_cnt, 1);
        measure("tick phase after reject", 3);

        for (int i = 6; i < 14; i++) run_vec(i);
        tick_cnt = 0;
        repeat (200) step();
        check("no ticks at level 0", tick_cnt, 0);
        pulse(1'b1);
        check("level 0 to 1", oLEVEL, 1);
        measure("first tick 28 after update (2 already elapsed)", 26);

        sat_cnt = 0;
        iENABLE = 1'b1;
        iUP_DOWN = 1'b1;
        repeat (50) step();
        iENABLE = 1'b0;
        repeat (4) step();
        check("held enable single increment", oLEVEL, 2);
        check("held enable no sat", sat_cnt, 0);

        repeat (5) pulse(1'b1);
        check("back at level 7", oLEVEL, 7);
        measure("sync before collision", -1);
        tick_cnt = 0;
        sat_cnt = 0;
        repeat (3) step();
        iENABLE = 1'b1;
        iUP_DOWN = 1'b1;
        step();
        iENABLE = 1'b0;
        step();
        iENABLE = 1'b1;
        iUP_DOWN = 1'b0;
        step();
        iENABLE = 1'b0;
        step();
        step();
        check("collision no tick", oTICK, 0);
        check("collision level", oLEVEL, 6);
        check("collision ticks before", tick_cnt, 1);
        check("collision up rejected", sat_cnt, 1);
        measure("tick after collision", 8);

        pulse(1'b0);
        check("level 5 before reset", oLEVEL, 5);
        measure("sync level 5", -1);
        repeat (7) step();
        #2;
        iRST = 1'b1;
        #1;
        check("async reset level", oLEVEL, 1);
        check("async reset tick", oTICK, 0);
        check("async reset sat", oSAT, 0);
        check("async reset min", oMIN, 0);
        #1;
        iRST = 1'b0;
        measure("tick after async reset", 28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
